// File: rtl/sub_arb_pkg.sv
// Shared definitions for the sub_arb_ctrl arbiter: op encoding, FSM states and
// the round-robin pick function.
package sub_arb_pkg;

    localparam int NREQ_DEFAULT = 4;
    localparam int RR_MAX       = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // One-hot grant for the first valid requester at or after ptr, wrapping at n.
    function automatic logic [RR_MAX-1:0] rr_pick(
        input logic [RR_MAX-1:0] valid,
        input int unsigned       ptr,
        input int unsigned       n
    );
        logic [RR_MAX-1:0] grant;
        logic              found;
        int unsigned       idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            idx = (ptr + k) % n;
            if (!found && (k < n) && valid[idx[2:0]]) begin
                grant[idx[2:0]] = 1'b1;
                found           = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/sub_arb_ctrl_addsub.sv
// Combinational 32-bit add/subtract; subtract is a + ~b + 1 so cout=1 means no borrow.
module addsub_unit
    import sub_arb_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        op_i,
    output logic [31:0] sum_o,
    output logic        cout_o,
    output logic        ovf_o
);

    logic [31:0] b_eff;
    logic [32:0] full;

    assign b_eff  = (op_i == OP_SUB) ? ~b_i : b_i;
    assign full   = {1'b0, a_i} + {1'b0, b_eff} + {32'd0, op_i};
    assign sum_o  = full[31:0];
    assign cout_o = full[32];
    assign ovf_o  = (a_i[31] == b_eff[31]) && (sum_o[31] != a_i[31]);

endmodule

// File: rtl/sub_arb_ctrl.sv
// Round-robin arbiter sharing one add/subtract unit among NREQ requesters.
// Define SUB_ARB_CTRL_OVF_EN to add the registered signed-overflow output rsp_ovf.
//   state   | meaning
//   ST_IDLE | granting the next requester, pointer-based round robin
//   ST_EXEC | latched operands through the adder, result captured
//   ST_RESP | result held; rsp_valid rises one cycle in, cleared on accept
module sub_arb_ctrl
    import sub_arb_pkg::*;
#(
    parameter  int NREQ       = NREQ_DEFAULT,
    parameter  int RR_EN_INIT = 0,
    localparam int IW         = $clog2(NREQ)
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_op,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IW-1:0]     rsp_id,
    output logic [31:0]       rsp_data,
`ifdef SUB_ARB_CTRL_OVF_EN
    output logic              rsp_ovf,
`endif
    output logic              rsp_cout
);

    state_t            st_q;
    logic [IW-1:0]     ptr_q, ptr_d, gnt_idx, id_q, rsp_id_q;
    logic              op_q, op_sel, rsp_valid_q, rsp_cout_q, alu_cout;
    logic [31:0]       a_q, b_q, a_sel, b_sel, rsp_data_q, alu_sum;
    logic [RR_MAX-1:0] valid_ext, gnt_ext;
    logic [NREQ-1:0]   gnt;
`ifdef SUB_ARB_CTRL_OVF_EN
    logic              alu_ovf, rsp_ovf_q;
`else
    logic              alu_ovf_unused;
`endif

    always_comb begin
        valid_ext             = '0;
        valid_ext[NREQ-1:0]   = req_valid;
        gnt_ext               = rr_pick(valid_ext, 32'(ptr_q), 32'(NREQ));
        gnt                   = (st_q == ST_IDLE && !clear) ? gnt_ext[NREQ-1:0] : '0;
        gnt_idx               = '0;
        op_sel                = OP_ADD;
        a_sel                 = '0;
        b_sel                 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = IW'(i);
                op_sel  = req_op[i];
                a_sel   = req_a[i*32 +: 32];
                b_sel   = req_b[i*32 +: 32];
            end
        end
        ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IW'(1);
    end

    addsub_unit u_addsub (
        .a_i    (a_q),
        .b_i    (b_q),
        .op_i   (op_q),
        .sum_o  (alu_sum),
        .cout_o (alu_cout),
`ifdef SUB_ARB_CTRL_OVF_EN
        .ovf_o  (alu_ovf)
`else
        .ovf_o  (alu_ovf_unused)
`endif
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            st_q        <= ST_IDLE;
            ptr_q       <= IW'(RR_EN_INIT);
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= '0;
`ifdef SUB_ARB_CTRL_OVF_EN
            rsp_ovf_q   <= 1'b0;
`endif
        end else begin
            case (st_q)
                ST_IDLE: begin
                    if (|gnt) begin
                        op_q  <= op_sel;
                        a_q   <= a_sel;
                        b_q   <= b_sel;
                        id_q  <= gnt_idx;
                        ptr_q <= ptr_d;
                        st_q  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_data_q <= alu_sum;
                    rsp_cout_q <= alu_cout;
                    rsp_id_q   <= id_q;
`ifdef SUB_ARB_CTRL_OVF_EN
                    rsp_ovf_q  <= alu_ovf;
`endif
                    st_q       <= ST_RESP;
                end
                ST_RESP: begin
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        st_q        <= ST_IDLE;
                    end
                end
                default: st_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = gnt;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_cout  = rsp_cout_q;
`ifdef SUB_ARB_CTRL_OVF_EN
    assign rsp_ovf   = rsp_ovf_q;
`endif

endmodule

// File: doc/sub_arb_ctrl.md
SUB_ARB_CTRL -- requirements
Module: sub_arb_ctrl

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the single 32-bit add/subtract unit; legal range 2..8.
REQ-002 Parameter RR_EN_INIT, default 0: requester index holding highest priority after reset.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 clear  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_op  input  NREQ  per-requester op select: 0 = A+B, 1 = A-B.
REQ-007 req_a, req_b  input  NREQ*32 each  flattened operands; requester i occupies bits [32i+31:32i].
REQ-008 req_ready  output  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i].
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_id  output  $clog2(NREQ)  index of requester owning the result.
REQ-012 rsp_data  output  32  sum or difference, modulo 2^32.
REQ-013 rsp_cout  output  1  carry out; for subtract, 1 means no borrow (A >= B unsigned).

Function
REQ-014 FSM states: IDLE, EXEC, RESP; one operation in flight at a time.
REQ-015 IDLE: req_ready asserted combinationally for exactly one requester, the first valid one at or after the priority pointer, wrapping NREQ-1 -> 0; all zero if no req_valid.
REQ-016 On transfer in IDLE: latch op, A, B, index; go to EXEC; pointer moves to (granted index + 1) mod NREQ.
REQ-017 EXEC: drive latched operands into the add/subtract unit; subtract as A + ~B + 1 (carry-in 1); register result, carry, id; go to RESP.
REQ-018 RESP: rsp_valid = 1; rsp_data, rsp_cout, rsp_id stable until rsp_valid & rsp_ready; then to IDLE.
REQ-019 Latency: transfer at edge N yields rsp_valid high after edge N+2; with rsp_ready held high, next grant possible in cycle following edge N+3.
REQ-020 req_ready all zero in EXEC and RESP; requests held pending with no loss.
REQ-021 Requester deasserting req_valid before grant is not served; no request latched without a transfer.
REQ-022 Boundary: A-B with A = B gives rsp_data 0, rsp_cout 1; 0-1 gives 0xFFFFFFFF, rsp_cout 0; 0xFFFFFFFF+1 gives 0, rsp_cout 1.
REQ-023 All NREQ valid continuously: grants rotate strictly 0,1,..,NREQ-1,0 from reset pointer; no starvation.

Reset
REQ-024 clear at an edge: state IDLE, pointer = RR_EN_INIT, rsp_valid 0, rsp_data 0, rsp_cout 0, rsp_id 0, latched operands 0.
REQ-025 clear mid-operation (EXEC or RESP) discards the in-flight result; no rsp_valid is produced for it.
REQ-026 While clear high, req_ready all zero.

Configuration
REQ-027 Macro SUB_ARB_CTRL_OVF_EN: when defined, output rsp_ovf (1 bit) = signed two's-complement overflow of the operation, registered with rsp_data, reset 0; when undefined, port and logic absent, all other behaviour identical.

Structure
REQ-028 Shared package sub_arb_pkg: op encoding constants OP_ADD = 0, OP_SUB = 1; FSM state typedef; default NREQ.
REQ-029 One sub-module, addsub_unit: combinational 32-bit add/subtract (A, B, op in; sum, cout, ovf out), instantiated once.
REQ-030 Round-robin pick is a function in the package, not a separate module.

Verification
REQ-031 Single request: req 2, op SUB, A=10, B=3 -> rsp_valid two edges after transfer, rsp_data 7, rsp_cout 1, rsp_id 2.
REQ-032 Borrow: A=0, B=1, SUB -> rsp_data 0xFFFFFFFF, rsp_cout 0; with SUB_ARB_CTRL_OVF_EN, rsp_ovf 0; A=0x80000000, B=1, SUB -> rsp_ovf 1.
REQ-033 Fairness: all four valid, rsp_ready 1, 8 operations -> rsp_id sequence 0,1,2,3,0,1,2,3.
REQ-034 Back-pressure: rsp_ready 0 for 5 cycles in RESP -> rsp_valid held, outputs stable, req_ready all zero; accepted on rsp_ready.
REQ-035 Reset mid-op: clear in EXEC -> next cycle IDLE, rsp_valid 0, pointer = RR_EN_INIT, no response emitted.
REQ-036 Add wrap: A=0xFFFFFFFF, B=1, ADD -> rsp_data 0, rsp_cout 1.
